// File: rtl/vga_painter_pkg.sv
// Shared types and default geometry for the full-screen VGA painter.
package vga_painter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    FLUSH,
    DONE
  } painter_state_t;

  localparam int DEF_H_RES       = 320;
  localparam int DEF_V_RES       = 240;
  localparam int DEF_COLOUR_W    = 3;
  localparam int DEF_NUM_SCREENS = 4;

endpackage

// File: rtl/vga_pixel_scanner.sv
// Raster scan counters: column, row and running row base address (no multiply).
module vga_pixel_scanner
  import vga_painter_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter int ADDR_W = 19
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_start,
  input  logic              i_adv,
  output logic [X_W-1:0]    o_sx,
  output logic [Y_W-1:0]    o_sy,
  output logic [ADDR_W-1:0] o_row_base,
  output logic              o_last
);

  logic [X_W-1:0]    r_sx;
  logic [Y_W-1:0]    r_sy;
  logic [ADDR_W-1:0] r_row_base;
  logic              w_x_end;
  logic              w_y_end;

  assign w_x_end = (r_sx == X_W'(H_RES - 1));
  assign w_y_end = (r_sy == Y_W'(V_RES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sx       <= '0;
      r_sy       <= '0;
      r_row_base <= '0;
    end else if (i_start) begin
      r_sx       <= '0;
      r_sy       <= '0;
      r_row_base <= '0;
    end else if (i_adv) begin
      if (w_x_end) begin
        r_sx <= '0;
        if (w_y_end) begin
          r_sy       <= '0;
          r_row_base <= '0;
        end else begin
          r_sy       <= r_sy + Y_W'(1);
          r_row_base <= r_row_base + ADDR_W'(H_RES);
        end
      end else begin
        r_sx <= r_sx + X_W'(1);
      end
    end
  end

  assign o_sx       = r_sx;
  assign o_sy       = r_sy;
  assign o_row_base = r_row_base;
  assign o_last     = w_x_end && w_y_end;

endmodule

// File: rtl/vga_screen_painter.sv
// Sweeps a selectable screen image out of a synchronous ROM into vga_adapter.
// Optional build macro PAINTER_TRANSPARENT_EN: colour-0 pixels are not plotted.
module vga_screen_painter
  import vga_painter_pkg::*;
#(
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int COLOUR_W    = DEF_COLOUR_W,
  parameter int NUM_SCREENS = DEF_NUM_SCREENS,
  parameter int SEL_W       = $clog2(NUM_SCREENS),
  parameter int ADDR_W      = $clog2(NUM_SCREENS * H_RES * V_RES)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [SEL_W-1:0]    screen_sel,
  input  logic                redraw,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                frame_done
);

  localparam int FRAME_PIX = H_RES * V_RES;

  painter_state_t    r_state;
  logic [SEL_W-1:0]  r_cur;
  logic [SEL_W-1:0]  r_pend;
  logic              r_pending;
  logic              r_boot;
  logic              r_chain;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_plot_vld;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;

  logic              w_sel_chg;
  logic              w_req;
  logic [SEL_W-1:0]  w_req_scr;
  logic              w_chain_now;
  logic [SEL_W-1:0]  w_chain_scr;
  logic              w_start;
  logic              w_adv;
  logic [X_W-1:0]    w_sx;
  logic [Y_W-1:0]    w_sy;
  logic [ADDR_W-1:0] w_row_base;
  logic [ADDR_W-1:0] w_frame_base;
  logic              w_last;

  // A selection change together with redraw collapses into one request for the new screen.
  always_comb begin
    w_sel_chg   = (int'(screen_sel) < NUM_SCREENS) && (screen_sel != r_cur);
    w_req       = w_sel_chg || redraw;
    w_req_scr   = w_sel_chg ? screen_sel : r_cur;
    w_chain_now = r_pending || w_req;
    w_chain_scr = w_req ? w_req_scr : r_pend;
    w_start     = ((r_state == IDLE) && (r_boot || w_chain_now)) ||
                  ((r_state == FLUSH) && w_chain_now);
    w_adv       = (r_state == SWEEP) || ((r_state == DONE) && r_chain);
  end

  vga_pixel_scanner #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .X_W   (X_W),
    .Y_W   (Y_W),
    .ADDR_W(ADDR_W)
  ) u_scanner (
    .clock     (clock),
    .resetn    (resetn),
    .i_start   (w_start),
    .i_adv     (w_adv),
    .o_sx      (w_sx),
    .o_sy      (w_sy),
    .o_row_base(w_row_base),
    .o_last    (w_last)
  );

  // A chained frame is decided at FLUSH so DONE already issues its first address,
  // leaving a single plot-free cycle between back-to-back frames.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_cur        <= '0;
      r_pend       <= '0;
      r_pending    <= 1'b0;
      r_boot       <= 1'b1;
      r_chain      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == FLUSH);
      case (r_state)
        IDLE: begin
          if (r_boot) begin
            r_boot    <= 1'b0;
            r_cur     <= '0;
            r_pending <= w_sel_chg;
            r_pend    <= screen_sel;
            r_state   <= SWEEP;
            r_busy    <= 1'b1;
          end else if (w_chain_now) begin
            r_cur     <= w_chain_scr;
            r_pending <= 1'b0;
            r_state   <= SWEEP;
            r_busy    <= 1'b1;
          end
        end
        SWEEP: begin
          if (w_req) begin
            r_pending <= 1'b1;
            r_pend    <= w_req_scr;
          end
          if (w_last) r_state <= FLUSH;
        end
        FLUSH: begin
          r_state <= DONE;
          r_chain <= w_chain_now;
          if (w_chain_now) begin
            r_cur     <= w_chain_scr;
            r_pending <= 1'b0;
          end
        end
        DONE: begin
          if (w_req) begin
            r_pending <= 1'b1;
            r_pend    <= w_req_scr;
          end
          r_chain <= 1'b0;
          if (r_chain) begin
            r_state <= SWEEP;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pixel stage: coordinates and valid follow the address stage by the ROM latency.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_plot_vld <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
    end else begin
      r_plot_vld <= w_adv;
      r_x        <= w_sx;
      r_y        <= w_sy;
    end
  end

  assign w_frame_base = ADDR_W'(r_cur) * ADDR_W'(FRAME_PIX);
  assign rom_addr     = w_frame_base + w_row_base + ADDR_W'(w_sx);
  assign x            = r_x;
  assign y            = r_y;
  assign colour       = r_plot_vld ? rom_q : '0;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;

`ifdef PAINTER_TRANSPARENT_EN
  assign plot = r_plot_vld && (rom_q != '0);
`else
  assign plot = r_plot_vld;
`endif

endmodule

// File: tb/tb_vga_screen_painter.sv
// Directed bench for vga_screen_painter on a 4x3, four-screen ROM (word = addr mod 8).
module tb_vga_screen_painter;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int NP = H * V;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] screen_sel = 3'd0;
  logic       redraw = 1'b0;
  logic [5:0] rom_addr;
  logic [2:0] rom_q = 3'd0;
  logic [2:0] x;
  logic [1:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  vga_screen_painter #(
    .H_RES      (H),
    .V_RES      (V),
    .X_W        (3),
    .Y_W        (2),
    .COLOUR_W   (3),
    .NUM_SCREENS(4),
    .SEL_W      (3),
    .ADDR_W     (6)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .screen_sel(screen_sel),
    .redraw    (redraw),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_q <= rom_addr[2:0];

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_plot"}, 32'(plot), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_fd"}, 32'(frame_done), 0);
  endtask

  // Entered on the cycle of the first plot; leaves on the DONE cycle.
  task automatic check_frame(input int scr, input int p1, input int s1, input int p2, input int s2);
    int col;
    int exp_plot;
    for (int i = 0; i < NP; i++) begin
      col = (scr * NP + i) % 8;
`ifdef PAINTER_TRANSPARENT_EN
      exp_plot = (col != 0) ? 1 : 0;
`else
      exp_plot = 1;
`endif
      chk($sformatf("s%0d_p%0d_x", scr, i), 32'(x), i % H);
      chk($sformatf("s%0d_p%0d_y", scr, i), 32'(y), i / H);
      chk($sformatf("s%0d_p%0d_col", scr, i), 32'(colour), col);
      chk($sformatf("s%0d_p%0d_plot", scr, i), 32'(plot), exp_plot);
      chk($sformatf("s%0d_p%0d_busy", scr, i), 32'(busy), 1);
      chk($sformatf("s%0d_p%0d_fd", scr, i), 32'(frame_done), 0);
      if (i < NP - 1) chk($sformatf("s%0d_p%0d_addr", scr, i), 32'(rom_addr), scr * NP + i + 1);
      if (i == p1) screen_sel = 3'(s1);
      if (i == p2) screen_sel = 3'(s2);
      if (i < NP - 1) tick();
    end
    tick();
    chk($sformatf("s%0d_done_plot", scr), 32'(plot), 0);
    chk($sformatf("s%0d_done_fd", scr), 32'(frame_done), 1);
    chk($sformatf("s%0d_done_busy", scr), 32'(busy), 1);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_col", 32'(colour), 0);
    chk_quiet("rst");

    // Case 1: screen 0 after reset release
    resetn = 1'b1;
    tick();
    chk("c1_start_busy", 32'(busy), 1);
    chk("c1_start_plot", 32'(plot), 0);
    chk("c1_start_addr", 32'(rom_addr), 0);
    tick();
    check_frame(0, -1, 0, -1, 0);
    tick();
    chk_quiet("c1_idle");

    // Case 2: select screen 2 from idle
    screen_sel = 3'd2;
    tick();
    chk("c2_addr", 32'(rom_addr), 24);
    chk("c2_busy", 32'(busy), 1);
    chk("c2_plot", 32'(plot), 0);
    tick();
    check_frame(2, -1, 0, -1, 0);
    tick();
    chk_quiet("c2_idle");

    // Case 3: requests mid-sweep, the latest one is chained after one gap cycle
    screen_sel = 3'd0;
    tick();
    chk("c3_addr", 32'(rom_addr), 0);
    tick();
    check_frame(0, 5, 1, 7, 3);
    chk("c3_chain_addr", 32'(rom_addr), 36);
    tick();
    check_frame(3, -1, 0, -1, 0);
    tick();
    chk_quiet("c3_idle0");
    tick();
    chk_quiet("c3_idle1");

    // Case 4: redraw of the current screen, then out-of-range selection
    redraw = 1'b1;
    tick();
    redraw = 1'b0;
    chk("c4_addr", 32'(rom_addr), 36);
    chk("c4_busy", 32'(busy), 1);
    tick();
    check_frame(3, -1, 0, -1, 0);
    tick();
    chk_quiet("c4_idle");
    screen_sel = 3'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_quiet($sformatf("c4_oor%0d", i));
    end

    // Simultaneous redraw and selection change: one frame of the new screen
    screen_sel = 3'd2;
    redraw = 1'b1;
    tick();
    redraw = 1'b0;
    chk("c4b_addr", 32'(rom_addr), 24);
    tick();
    check_frame(2, -1, 0, -1, 0);
    tick();
    chk_quiet("c4b_idle0");
    tick();
    chk_quiet("c4b_idle1");

    // Case 5: reset asserted at pixel 6 of a screen-1 sweep
    screen_sel = 3'd1;
    tick();
    chk("c5_addr", 32'(rom_addr), 12);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("c5_p%0d_x", i), 32'(x), i % H);
      tick();
    end
    chk("c5_p6_plot", 32'(plot), 1);
    chk("c5_p6_busy", 32'(busy), 1);
    resetn = 1'b0;
    screen_sel = 3'd0;
    #1;
    chk("c5_rst_addr", 32'(rom_addr), 0);
    chk("c5_rst_x", 32'(x), 0);
    chk("c5_rst_col", 32'(colour), 0);
    chk_quiet("c5_rst");
    tick();
    chk_quiet("c5_rst_hold");
    resetn = 1'b1;
    tick();
    chk("c5_rel_busy", 32'(busy), 1);
    chk("c5_rel_addr", 32'(rom_addr), 0);
    tick();
    check_frame(0, -1, 0, -1, 0);
    tick();
    chk_quiet("c5_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
